// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the video-clock PLL lock sequencer.
// State encodings are visible to software through the status PIO.
package pll_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StArm  = 3'd0,
        StWait = 3'd1,
        StQual = 3'd2,
        StRun  = 3'd3,
        StFail = 3'd4
    } seq_state_e;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for level signals crossing into the clk domain.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Arms the video PLL, qualifies its lock, and releases the pixel-domain reset once stable.
// Watches for sustained lock loss in RUN and re-arms automatically or on a rearm pulse.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned GLITCH_CYCLES = 4,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               rearm,
    output logic               pll_rst,
    output logic               clk_ok,
    output logic               out_rst_n,
    output logic               fail,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   loss_cnt
);

    localparam int unsigned T_MAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned T_MAX    = (T_MAX_A > STABLE_CYCLES) ? T_MAX_A : STABLE_CYCLES;
    localparam int unsigned TIMER_W  = $clog2(T_MAX) + 1;
    localparam int unsigned RETRY_W  = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int unsigned GLITCH_W = (GLITCH_CYCLES < 2) ? 1 : $clog2(GLITCH_CYCLES + 1);

    localparam logic [TIMER_W-1:0]  RST_LAST    = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  TO_LAST     = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYCLES - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    logic                lk;
    seq_state_e          state_q;
    logic [TIMER_W-1:0]  timer_q;
    logic [RETRY_W-1:0]  retries_q;
    logic [RETRY_W-1:0]  retries_inc;
    logic [GLITCH_W-1:0] glitch_q;
    logic [CNT_W-1:0]    loss_q;
    logic                pll_rst_q;
    logic                clk_ok_q;
    logic                out_rst_n_q;
    logic                fail_q;

    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    // Retries never exceed MAX_RETRIES, so this cannot overflow RETRY_W.
    assign retries_inc = retries_q + RETRY_W'(1);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StArm;
            timer_q     <= '0;
            retries_q   <= '0;
            glitch_q    <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            clk_ok_q    <= 1'b0;
            out_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            out_rst_n_q <= clk_ok_q;
            if (rearm) begin
                state_q   <= StArm;
                timer_q   <= '0;
                retries_q <= '0;
                glitch_q  <= '0;
                pll_rst_q <= 1'b1;
                clk_ok_q  <= 1'b0;
                fail_q    <= 1'b0;
            end else begin
                case (state_q)
                    StArm: begin
                        if (timer_q == RST_LAST) begin
                            state_q   <= StWait;
                            timer_q   <= '0;
                            pll_rst_q <= 1'b0;
                        end else begin
                            timer_q <= timer_q + TIMER_W'(1);
                        end
                    end
                    StWait: begin
                        if (lk) begin
                            state_q <= StQual;
                            timer_q <= '0;
                        end else if (timer_q == TO_LAST) begin
                            timer_q   <= '0;
                            retries_q <= retries_inc;
                            pll_rst_q <= 1'b1;
                            if (retries_inc >= RETRY_MAX) begin
                                state_q <= StFail;
                                fail_q  <= 1'b1;
                            end else begin
                                state_q <= StArm;
                            end
                        end else begin
                            timer_q <= timer_q + TIMER_W'(1);
                        end
                    end
                    StQual: begin
                        // A dropout only restarts the wait; it is not a retry or a loss.
                        if (!lk) begin
                            state_q <= StWait;
                            timer_q <= '0;
                        end else if (timer_q == STABLE_LAST) begin
                            state_q   <= StRun;
                            timer_q   <= '0;
                            retries_q <= '0;
                            clk_ok_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TIMER_W'(1);
                        end
                    end
                    StRun: begin
                        if (lk) begin
                            glitch_q <= '0;
                        end else if (glitch_q == GLITCH_LAST) begin
                            state_q   <= StArm;
                            timer_q   <= '0;
                            glitch_q  <= '0;
                            pll_rst_q <= 1'b1;
                            clk_ok_q  <= 1'b0;
                            if (loss_q != '1) begin
                                loss_q <= loss_q + CNT_W'(1);
                            end
                        end else begin
                            glitch_q <= glitch_q + GLITCH_W'(1);
                        end
                    end
                    StFail: begin
                        pll_rst_q <= 1'b1;
                        fail_q    <= 1'b1;
                    end
                    default: begin
                        state_q   <= StArm;
                        timer_q   <= '0;
                        glitch_q  <= '0;
                        pll_rst_q <= 1'b1;
                        clk_ok_q  <= 1'b0;
                        fail_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pll_rst   = pll_rst_q;
    assign clk_ok    = clk_ok_q;
    assign out_rst_n = out_rst_n_q;
    assign fail      = fail_q;
    assign state_o   = state_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized bench for pll_lock_sequencer against a cycle-level behavioural model.
module tb_pll_lock_sequencer;

    localparam int unsigned RST_C = 4;
    localparam int unsigned TO_C  = 100;
    localparam int unsigned STB_C = 8;
    localparam int unsigned GL_C  = 3;
    localparam int unsigned MR_C  = 2;
    localparam int unsigned CW    = 2;

    localparam int P_ARM  = 0;
    localparam int P_WAIT = 1;
    localparam int P_QUAL = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic          refclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          rearm = 1'b0;
    logic          pll_rst;
    logic          clk_ok;
    logic          out_rst_n;
    logic          fail;
    logic [2:0]    state_o;
    logic [CW-1:0] loss_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase number, cycles spent in phase, failed attempts, lk-low run, losses.
    int m_phase, m_dwell, m_retries, m_lo, m_loss, m_orst, m_s1, m_lk;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (STB_C),
        .GLITCH_CYCLES (GL_C),
        .MAX_RETRIES   (MR_C),
        .CNT_W         (CW)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .rearm      (rearm),
        .pll_rst    (pll_rst),
        .clk_ok     (clk_ok),
        .out_rst_n  (out_rst_n),
        .fail       (fail),
        .state_o    (state_o),
        .loss_cnt   (loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_ARM;
        m_dwell   = 0;
        m_retries = 0;
        m_lo      = 0;
        m_loss    = 0;
        m_orst    = 0;
        m_s1      = 0;
        m_lk      = 0;
    endtask

    // Advances the model by one refclk edge given the inputs held across it.
    task automatic model_step(input int pl, input int ra);
        int lk_use;
        lk_use = m_lk;
        m_lk   = m_s1;
        m_s1   = pl;
        m_orst = (m_phase == P_RUN) ? 1 : 0;
        if (ra != 0) begin
            m_phase   = P_ARM;
            m_dwell   = 0;
            m_retries = 0;
            m_lo      = 0;
        end else if (m_phase == P_ARM) begin
            m_dwell++;
            if (m_dwell == RST_C) begin
                m_phase = P_WAIT;
                m_dwell = 0;
            end
        end else if (m_phase == P_WAIT) begin
            if (lk_use != 0) begin
                m_phase = P_QUAL;
                m_dwell = 0;
            end else begin
                m_dwell++;
                if (m_dwell == TO_C) begin
                    m_retries++;
                    m_phase = (m_retries >= MR_C) ? P_FAIL : P_ARM;
                    m_dwell = 0;
                end
            end
        end else if (m_phase == P_QUAL) begin
            if (lk_use == 0) begin
                m_phase = P_WAIT;
                m_dwell = 0;
            end else begin
                m_dwell++;
                if (m_dwell == STB_C) begin
                    m_phase   = P_RUN;
                    m_dwell   = 0;
                    m_retries = 0;
                    m_lo      = 0;
                end
            end
        end else if (m_phase == P_RUN) begin
            m_lo = (lk_use != 0) ? 0 : m_lo + 1;
            if (m_lo == GL_C) begin
                m_phase = P_ARM;
                m_dwell = 0;
                m_lo    = 0;
                if (m_loss < (1 << CW) - 1) m_loss++;
            end
        end
    endtask

    task automatic compare_all();
        check("state", state_o, m_phase);
        check("pll_rst", pll_rst, (m_phase == P_ARM || m_phase == P_FAIL));
        check("clk_ok", clk_ok, (m_phase == P_RUN));
        check("out_rst_n", out_rst_n, m_orst);
        check("fail", fail, (m_phase == P_FAIL));
        check("loss_cnt", loss_cnt, m_loss);
    endtask

    // Inputs change on the falling edge; outputs are compared one falling edge later.
    task automatic cycle(input logic pl, input logic ra);
        pll_locked = pl;
        rearm      = ra;
        model_step(int'(pl), int'(ra));
        @(negedge refclk);
        compare_all();
        rearm = 1'b0;
    endtask

    initial begin
        int lvl, len, r;
        model_reset();
        repeat (3) @(negedge refclk);
        compare_all();
        rst_n = 1'b1;

        // Clean lock after 10 cycles in WAIT.
        repeat (RST_C + 10) cycle(1'b0, 1'b0);
        repeat (30) cycle(1'b1, 1'b0);

        // Short glitch is filtered; a longer one is a loss.
        repeat (2) cycle(1'b0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0);
        repeat (GL_C) cycle(1'b0, 1'b0);
        repeat (12) cycle(1'b0, 1'b0);

        // Qualification bounce then relock.
        repeat (5) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        repeat (25) cycle(1'b1, 1'b0);

        // Rearm from RUN.
        cycle(1'b1, 1'b1);
        repeat (30) cycle(1'b1, 1'b0);

        // Lock never returns: two attempts then FAIL, then rearm out of it.
        repeat (2 * (RST_C + TO_C) + 20) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);

        // Rearm landing on the timeout that would otherwise enter FAIL.
        for (int i = 0; i < 400; i++) begin
            if (m_phase == P_WAIT && m_dwell == TO_C - 1 && m_retries == MR_C - 1) break;
            cycle(1'b0, 1'b0);
        end
        cycle(1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0);

        // Randomized lock behaviour with occasional rearm pulses.
        for (int s = 0; s < 60; s++) begin
            lvl = $urandom_range(0, 1);
            if (lvl != 0) begin
                len = $urandom_range(1, 20);
            end else begin
                r   = $urandom_range(0, 9);
                len = (r < 6) ? $urandom_range(1, 4) : (r < 9) ? $urandom_range(5, 40) : 220;
            end
            for (int i = 0; i < len; i++) cycle(lvl[0], ($urandom_range(0, 63) == 0));
        end

        // Asynchronous reset in the middle of qualification.
        cycle(1'b0, 1'b1);
        repeat (RST_C + 6) cycle(1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 1'b0);
            if (m_phase == P_QUAL && m_dwell >= 3) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge refclk);
        compare_all();
        rst_n = 1'b1;
        repeat (RST_C + 3) cycle(1'b0, 1'b0);
        repeat (20) cycle(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
